// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO read-side unpacker: width derivation and slice-order encoding.
package fifo_pkg;

    localparam bit ORDER_LSB_FIRST = 1'b1;
    localparam bit ORDER_MSB_FIRST = 1'b0;

    typedef logic [1:0] wbuf_count_t;

    function automatic int unsigned calc_ratio(input int unsigned data_width,
                                               input int unsigned out_width);
        return data_width / out_width;
    endfunction

    function automatic int unsigned calc_clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // A one-bit index is kept even for degenerate ratios so the counter never collapses to zero width.
    function automatic int unsigned calc_idxw(input int unsigned ratio);
        return (ratio < 2) ? 1 : calc_clog2(ratio);
    endfunction

endpackage

// File: rtl/unpack_wbuf.sv
// Two-entry word buffer between the FIFO read port and the beat serialiser.
module unpack_wbuf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output wbuf_count_t           count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] entry [2];
    logic                  head_ptr;
    logic                  tail_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= '0;
        end else begin
            if (wr_en) begin
                entry[tail_ptr] <= wr_data;
                tail_ptr        <= !tail_ptr;
            end
            if (rd_en) begin
                head_ptr <= !head_ptr;
            end
            // Simultaneous write and retire leaves the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = entry[head_ptr];

endmodule

// File: rtl/fifo_rd_unpack.sv
// Pops words from the dual-clock FIFO read port and serialises each into narrower valid/ready beats.
module fifo_rd_unpack
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset_n,
    output logic                  fifo_rd_req,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int unsigned     RATIO    = calc_ratio(DATA_WIDTH, OUT_WIDTH);
    localparam int unsigned     IDXW     = calc_idxw(RATIO);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);

    wbuf_count_t           count;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  inflight;
    logic                  pop_ok;
    logic [IDXW-1:0]       idx;
    logic [IDXW-1:0]       sel;
    logic                  last_slice;
    logic                  xfer;
    logic                  retire;
    logic [OUT_WIDTH-1:0]  slices [RATIO];

    // Words already requested count against capacity, so the buffer can never overflow.
    assign pop_ok      = !fifo_rd_empty && ((count + {1'b0, inflight}) < 2'd2);
    assign fifo_rd_req = pop_ok && rd_reset_n;

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_req;
        end
    end

    unpack_wbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wbuf (
        .clk       (rd_clk),
        .rst_n     (rd_reset_n),
        .wr_en     (inflight),
        .wr_data   (fifo_data_out),
        .rd_en     (retire),
        .count     (count),
        .head_data (head_data)
    );

    assign out_valid  = (count != '0);
    assign last_slice = (idx == IDX_LAST);
    assign out_last   = out_valid && last_slice;
    assign xfer       = out_valid && out_ready;
    assign retire     = xfer && last_slice;
    assign busy       = out_valid || inflight;

    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= last_slice ? '0 : idx + 1'b1;
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        assign slices[g] = head_data[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign sel      = (LSB_FIRST == ORDER_LSB_FIRST) ? idx : (IDX_LAST - idx);
    assign out_data = out_valid ? slices[sel] : '0;

    a_no_pop_when_empty : assert property (@(posedge rd_clk) disable iff (!rd_reset_n)
        !(fifo_rd_req && fifo_rd_empty));
    a_count_in_range : assert property (@(posedge rd_clk) disable iff (!rd_reset_n)
        count <= 2'd2);

endmodule
